// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared types and defaults for led_pattern_gen (LED_PATTERN_GEN_DEBOUNCE_EN)
package led_pattern_pkg;

   typedef enum logic [1:0] {
      MODE_BLINK = 2'd0,
      MODE_WALK  = 2'd1,
      MODE_COUNT = 2'd2
   } mode_t;

   localparam int PERIOD_W         = 8;
   localparam int PERIOD_DEF_TICKS = 5;
   localparam logic [4*PERIOD_W-1:0] PERIOD_TAB_DEF = {8'd20, 8'd12, 8'd8, 8'd2};

   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_BLINK: return MODE_WALK;
         MODE_WALK:  return MODE_COUNT;
         default:    return MODE_BLINK;
      endcase
   endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - key synchroniser, debounce filter (LED_PATTERN_GEN_DEBOUNCE_EN) and press pulse
module key_debounce #(
   parameter int DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key,
   output logic press
);

   logic       sync_a;
   logic       sync_b;
   logic       level;
   logic       level_d;
   logic [1:0] fill;
   logic       armed;

   // two-flop synchroniser, idles at released
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
      end else begin
         sync_a <= key;
         sync_b <= sync_a;
      end
   end

`ifdef LED_PATTERN_GEN_DEBOUNCE_EN
   localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   logic [CNT_W-1:0] cnt;

   // accept a new level after DEBOUNCE_CYC consecutive differing samples; a bounce restarts
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level <= 1'b1;
         cnt   <= '0;
      end else if (sync_b == level) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
         level <= sync_b;
         cnt   <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
`else
   assign level = sync_b;
`endif

   // arm only once the synchronised key is seen released, so a key held through reset is ignored
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill    <= 2'b00;
         armed   <= 1'b0;
         level_d <= 1'b1;
      end else begin
         fill    <= {fill[0], 1'b1};
         armed   <= armed | (fill[1] & sync_b);
         level_d <= level;
      end
   end

   assign press = armed & level_d & ~level;

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - key-driven LED pattern generator top (LED_PATTERN_GEN_DEBOUNCE_EN)
module led_pattern_gen
   import led_pattern_pkg::*;
#(
   parameter int CLK_FREQ     = 27_000_000,
   parameter int IO_COUNT     = 104,
   parameter int KEY_COUNT    = 4,
   parameter int TICK_DIV     = CLK_FREQ / 10,
   parameter int PERIOD_DEF   = PERIOD_DEF_TICKS,
   parameter logic [KEY_COUNT*PERIOD_W-1:0] PERIOD_TAB = PERIOD_TAB_DEF,
   parameter int DEBOUNCE_CYC = CLK_FREQ / 50
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [KEY_COUNT-1:0] user_key,
   output logic [IO_COUNT-1:0]  led_o,
   output logic [1:0]           mode_o,
   output logic                 step_o
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [KEY_COUNT-1:0] press;
   logic                 key_hit;
   logic [PERIOD_W-1:0]  key_period;

   mode_t                mode;
   mode_t                mode_next;
   logic [PERIOD_W-1:0]  period;
   logic [PERIOD_W-1:0]  period_next;
   logic [IO_COUNT-1:0]  led;
   logic [IO_COUNT-1:0]  led_next;
   logic                 step;
   logic                 step_next;

   logic [TICK_W-1:0]    tick_cnt;
   logic [PERIOD_W-1:0]  step_cnt;
   logic                 tick;
   logic                 step_now;

   genvar g;
   generate
      for (g = 0; g < KEY_COUNT; g++) begin : g_key
         key_debounce #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC)
         ) u_key (
            .clk   (clk),
            .rst_n (rst_n),
            .key   (user_key[g]),
            .press (press[g])
         );
      end
   endgenerate

   // lowest-index press event wins; its table entry is the candidate period
   always_comb begin
      key_hit    = 1'b0;
      key_period = '0;
      for (int k = KEY_COUNT - 1; k >= 0; k--) begin
         if (press[k]) begin
            key_hit    = 1'b1;
            key_period = PERIOD_TAB[k*PERIOD_W +: PERIOD_W];
         end
      end
   end

   assign tick     = (tick_cnt == TICK_W'(TICK_DIV - 1));
   assign step_now = tick && (step_cnt == period - 1'b1);

   // base-tick prescaler, restarted by every press event
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_cnt <= '0;
      end else if (key_hit || tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // tick counter within one step period, restarted by every press event
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         step_cnt <= '0;
      end else if (key_hit) begin
         step_cnt <= '0;
      end else if (tick) begin
         step_cnt <= step_now ? '0 : step_cnt + 1'b1;
      end
   end

   // state register: mode, period, pattern and step pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mode   <= MODE_BLINK;
         period <= PERIOD_W'(PERIOD_DEF);
         led    <= '0;
         step   <= 1'b0;
      end else begin
         mode   <= mode_next;
         period <= period_next;
         led    <= led_next;
         step   <= step_next;
      end
   end

   // next state: a new key loads its period, the same key again advances the mode
   always_comb begin
      mode_next   = mode;
      period_next = period;
      if (key_hit) begin
         if (key_period != period) begin
            period_next = key_period;
         end else begin
            mode_next = next_mode(mode);
         end
      end
   end

   // pattern output: entry pattern on a press event, otherwise advance on the terminal tick
   always_comb begin
      led_next  = led;
      step_next = 1'b0;
      if (key_hit) begin
         led_next = '0;
         if (mode_next == MODE_WALK) begin
            led_next[0] = 1'b1;
         end
      end else if (step_now) begin
         step_next = 1'b1;
         case (mode)
            MODE_BLINK: led_next = ~led;
            MODE_WALK:  led_next = {led[IO_COUNT-2:0], led[IO_COUNT-1]};
            default:    led_next = led + 1'b1;
         endcase
      end
   end

   assign led_o  = led;
   assign mode_o = mode;
   assign step_o = step;

endmodule
